int_stim_gen: RTL and testbench

//  Parametrised interrupt stimulus generator for the P7 CPU benches; replaces the ad-hoc negedge interrupt process.

---
 rtl/int_stim_pkg.sv | 18 +
 rtl/int_stim_chan.sv | 94 +++++++++
 rtl/int_stim_gen.sv | 47 ++++
 tb/tb_int_stim_gen.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/int_stim_pkg.sv
// rtl/int_stim_pkg.sv - shared types, constants and helpers for the interrupt stimulus generator
package int_stim_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int ACK_STRIDE = 4;
    localparam int CNT_W      = 16;

    function automatic logic word_eq(input logic [31:0] a, input logic [31:0] b);
        return (a & ~32'd3) == (b & ~32'd3);
    endfunction

endpackage

// File: rtl/int_stim_chan.sv
// rtl/int_stim_chan.sv - one interrupt channel: trigger/ack FSM, pulse timer and firing counter
module int_stim_chan
    import int_stim_pkg::*;
#(
    parameter int          MODE       = 0,
    parameter int          PULSE_LEN  = 4,
    parameter int          FIRE_LIMIT = 1,
    parameter logic [31:0] TARGET     = 32'h0000301c,
    parameter logic [31:0] ACK_ADDR   = 32'h00007f20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_addr,
    input  logic [3:0]       i_byteen,
    output logic             o_int,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_done
);

    localparam int TW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    state_t           r_state, w_state_nxt;
    logic             r_int, w_int_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [TW-1:0]    r_timer, w_timer_nxt;

    logic w_match;
    logic w_ack;
    logic w_timeout;
    logic w_limit_hit;

    assign w_match     = word_eq(i_pc, TARGET);
    assign w_ack       = (|i_byteen) && word_eq(i_addr, ACK_ADDR);
    assign w_timeout   = (MODE == 1) && (r_timer == TW'(PULSE_LEN - 1));
    assign w_limit_hit = (FIRE_LIMIT != 0) && (r_cnt == CNT_W'(FIRE_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_int   <= 1'b0;
            r_cnt   <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_int   <= w_int_nxt;
            r_cnt   <= w_cnt_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_int_nxt   = r_int;
        w_cnt_nxt   = r_cnt;
        w_timer_nxt = r_timer;
        case (r_state)
            IDLE: begin
                if (w_match) begin
                    w_state_nxt = ASSERT;
                    w_int_nxt   = 1'b1;
                    w_timer_nxt = '0;
                    w_cnt_nxt   = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
                end
            end
            ASSERT: begin
                if (w_ack || w_timeout) begin
                    w_state_nxt = HOLD;
                    w_int_nxt   = 1'b0;
                end else if (MODE == 1) begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            HOLD: begin
                // A PC parked on the target must leave it before the channel re-arms.
                if (!w_match) begin
                    w_state_nxt = w_limit_hit ? DONE : IDLE;
                end
            end
            DONE: begin
                w_int_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_int_nxt   = 1'b0;
            end
        endcase
    end

    assign o_int  = r_int;
    assign o_cnt  = r_cnt;
    assign o_done = (r_state == DONE);

endmodule

// File: rtl/int_stim_gen.sv
// rtl/int_stim_gen.sv - multi-channel PC-triggered interrupt stimulus generator
module int_stim_gen
    import int_stim_pkg::*;
#(
    parameter int                NCH        = 1,
    parameter logic [NCH*32-1:0] TARGET_PCS = 32'h0000301c,
    parameter logic [31:0]       ACK_BASE   = 32'h00007f20,
    parameter int                FIRE_LIMIT = 1,
    parameter int                MODE       = 0,
    parameter int                PULSE_LEN  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          macroscopic_pc,
    input  logic [31:0]          m_int_addr,
    input  logic [3:0]           m_int_byteen,
    output logic                 interrupt,
    output logic [NCH-1:0]       int_vec,
    output logic [NCH*CNT_W-1:0] fire_cnt,
    output logic                 all_done
);

    logic [NCH-1:0] w_done;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        int_stim_chan #(
            .MODE       (MODE),
            .PULSE_LEN  (PULSE_LEN),
            .FIRE_LIMIT (FIRE_LIMIT),
            .TARGET     (TARGET_PCS[k*32 +: 32]),
            .ACK_ADDR   (ACK_BASE + 32'(ACK_STRIDE * k))
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .i_pc     (macroscopic_pc),
            .i_addr   (m_int_addr),
            .i_byteen (m_int_byteen),
            .o_int    (int_vec[k]),
            .o_cnt    (fire_cnt[k*CNT_W +: CNT_W]),
            .o_done   (w_done[k])
        );
    end

    assign interrupt = |int_vec;
    assign all_done  = &w_done;

endmodule

// File: tb/tb_int_stim_gen.sv
// tb/tb_int_stim_gen.sv - directed self-checking bench for int_stim_gen
module tb_int_stim_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [3:0]  be;

    logic        d_irq, p_irq, t_irq, u_irq;
    logic [0:0]  d_vec, p_vec, u_vec;
    logic [1:0]  t_vec;
    logic [15:0] d_cnt, p_cnt, u_cnt;
    logic [31:0] t_cnt;
    logic        d_done, p_done, t_done, u_done;

    int vectors     = 0;
    int miscompares = 0;
    int hi;

    always #5 clk = ~clk;

    int_stim_gen u_def (
        .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_int_addr(addr), .m_int_byteen(be),
        .interrupt(d_irq), .int_vec(d_vec), .fire_cnt(d_cnt), .all_done(d_done)
    );

    int_stim_gen #(.MODE(1), .PULSE_LEN(4), .FIRE_LIMIT(0)) u_pulse (
        .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_int_addr(addr), .m_int_byteen(be),
        .interrupt(p_irq), .int_vec(p_vec), .fire_cnt(p_cnt), .all_done(p_done)
    );

    int_stim_gen #(.NCH(2), .TARGET_PCS({32'h00003040, 32'h00003020})) u_two (
        .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_int_addr(addr), .m_int_byteen(be),
        .interrupt(t_irq), .int_vec(t_vec), .fire_cnt(t_cnt), .all_done(t_done)
    );

    int_stim_gen #(.FIRE_LIMIT(0)) u_unl (
        .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_int_addr(addr), .m_int_byteen(be),
        .interrupt(u_irq), .int_vec(u_vec), .fire_cnt(u_cnt), .all_done(u_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pc    = 32'h0;
        addr  = 32'h0;
        be    = 4'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // 1: level mode, single fire, ack three cycles later
        check_val("rst_vec", 32'(d_vec), 32'h0);
        check_val("rst_irq", 32'(d_irq), 32'h0);
        check_val("rst_cnt", 32'(d_cnt), 32'h0);
        check_val("rst_done", 32'(d_done), 32'h0);
        pc = 32'h3018; tick();
        check_val("t1_pre", 32'(d_irq), 32'h0);
        hi = 0;
        pc = 32'h301c; tick(); hi += int'(d_irq);
        check_val("t1_cnt", 32'(d_cnt), 32'h1);
        pc = 32'h3020; tick(); hi += int'(d_irq);
        tick(); hi += int'(d_irq);
        addr = 32'h7f20; be = 4'hf; tick(); hi += int'(d_irq);
        be = 4'h0;
        check_val("t1_hi", 32'(hi), 32'd3);
        tick();
        check_val("t1_done", 32'(d_done), 32'h1);
        pc = 32'h301c; tick(); tick();
        check_val("t1_nofire", 32'(d_vec), 32'h0);
        check_val("t1_cnt2", 32'(d_cnt), 32'h1);

        // 2: pulse mode, timeout then early ack
        do_reset();
        hi = 0;
        pc = 32'h301c; tick(); hi += int'(p_irq);
        pc = 32'h0;
        for (int i = 0; i < 5; i++) begin
            tick(); hi += int'(p_irq);
        end
        check_val("t2_hi", 32'(hi), 32'd4);
        check_val("t2_cnt", 32'(p_cnt), 32'h1);
        hi = 0;
        pc = 32'h301c; tick(); hi += int'(p_irq);
        pc = 32'h0; tick(); hi += int'(p_irq);
        addr = 32'h7f20; be = 4'hf; tick(); hi += int'(p_irq);
        be = 4'h0;
        for (int i = 0; i < 4; i++) begin
            tick(); hi += int'(p_irq);
        end
        check_val("t2_ack_hi", 32'(hi), 32'd2);
        check_val("t2_cnt2", 32'(p_cnt), 32'h2);

        // 3: two channels, independent acks, byte store unaligned
        do_reset();
        pc = 32'h3020; tick();
        check_val("t3_v01", 32'(t_vec), 32'h1);
        pc = 32'h3040; tick();
        check_val("t3_v11", 32'(t_vec), 32'h3);
        check_val("t3_irq", 32'(t_irq), 32'h1);
        pc = 32'h0; addr = 32'h7f25; be = 4'b0010; tick();
        check_val("t3_ack1", 32'(t_vec), 32'h1);
        addr = 32'h7f20; be = 4'hf; tick();
        be = 4'h0;
        check_val("t3_ack0", 32'(t_vec), 32'h0);
        check_val("t3_cnt", t_cnt, 32'h0001_0001);
        tick();
        check_val("t3_done", 32'(t_done), 32'h1);

        // 4: unlimited firing, PC stalled on target must not refire
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pc = 32'h301c; tick();
            pc = 32'h0; addr = 32'h7f20; be = 4'hf; tick();
            be = 4'h0; tick();
        end
        check_val("t4_cnt", 32'(u_cnt), 32'd5);
        check_val("t4_done", 32'(u_done), 32'h0);
        pc = 32'h301c; tick();
        addr = 32'h7f20; be = 4'hf; tick();
        be = 4'h0;
        for (int i = 0; i < 10; i++) tick();
        check_val("t4_stall_vec", 32'(u_vec), 32'h0);
        check_val("t4_stall_cnt", 32'(u_cnt), 32'd6);
        check_val("t4_stall_done", 32'(u_done), 32'h0);

        // 5: ack in IDLE ignored; match plus ack on same edge fires
        do_reset();
        addr = 32'h7f20; be = 4'hf; tick();
        be = 4'h0;
        check_val("t5_idle_ack", 32'(d_vec), 32'h0);
        pc = 32'h301c; tick();
        check_val("t5_fire", 32'(d_vec), 32'h1);
        check_val("t5_cnt", 32'(d_cnt), 32'h1);
        do_reset();
        pc = 32'h301c; addr = 32'h7f20; be = 4'hf; tick();
        be = 4'h0;
        check_val("t5_same_edge", 32'(d_vec), 32'h1);

        // 6: reset mid-assert
        do_reset();
        pc = 32'h301c; tick();
        check_val("t6_pre", 32'(d_vec), 32'h1);
        reset = 1'b1; tick();
        check_val("t6_rst_vec", 32'(d_vec), 32'h0);
        check_val("t6_rst_cnt", 32'(d_cnt), 32'h0);
        reset = 1'b0; pc = 32'h0; tick();
        pc = 32'h301c; tick();
        check_val("t6_refire", 32'(d_vec), 32'h1);
        check_val("t6_recnt", 32'(d_cnt), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
